rotate_tile_sequencer: RTL and testbench

//  Frame-level scheduler for the pixel rotation core. On START it walks the source image in 8x8-pixel tiles,
//  row-major. Per tile it issues a DMA read, triggers one core pixel pass, then issues a DMA write to the

---
 rtl/rotate_tile_sequencer_if.sv | 39 +++
 rtl/rotate_tile_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_rotate_tile_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotate_tile_sequencer_if.sv
// Handshake and configuration bundle between the rotation tile sequencer and its DMA/core/host side.
// master = sequencer (issues tile requests), slave = environment (config, acks, completions).
interface rotate_tile_sequencer_if #(
  parameter int P_ADDR_W = 32
);
  logic                I_TS_RESET;
  logic                I_TS_START;
  logic [15:0]         I_TS_WIDTH;
  logic [15:0]         I_TS_HEIGHT;
  logic [1:0]          I_TS_DEGREES;
  logic                I_TS_DIRECTION;
  logic [P_ADDR_W-1:0] I_TS_SRC_BASE;
  logic [P_ADDR_W-1:0] I_TS_DST_BASE;
  logic                O_TS_RD_REQ;
  logic                O_TS_WR_REQ;
  logic [P_ADDR_W-1:0] O_TS_ADDR;
  logic [15:0]         O_TS_STRIDE;
  logic                I_TS_ACK;
  logic                I_TS_XFER_DONE;
  logic                O_TS_CORE_GO;
  logic                I_TS_CORE_DONE;
  logic                O_TS_BUSY;
  logic                O_TS_DONE;
  logic                O_TS_ERR;

  modport master (
    input  I_TS_RESET, I_TS_START, I_TS_WIDTH, I_TS_HEIGHT, I_TS_DEGREES, I_TS_DIRECTION,
           I_TS_SRC_BASE, I_TS_DST_BASE, I_TS_ACK, I_TS_XFER_DONE, I_TS_CORE_DONE,
    output O_TS_RD_REQ, O_TS_WR_REQ, O_TS_ADDR, O_TS_STRIDE, O_TS_CORE_GO,
           O_TS_BUSY, O_TS_DONE, O_TS_ERR
  );

  modport slave (
    output I_TS_RESET, I_TS_START, I_TS_WIDTH, I_TS_HEIGHT, I_TS_DEGREES, I_TS_DIRECTION,
           I_TS_SRC_BASE, I_TS_DST_BASE, I_TS_ACK, I_TS_XFER_DONE, I_TS_CORE_DONE,
    input  O_TS_RD_REQ, O_TS_WR_REQ, O_TS_ADDR, O_TS_STRIDE, O_TS_CORE_GO,
           O_TS_BUSY, O_TS_DONE, O_TS_ERR
  );
endinterface

// File: rtl/rotate_tile_sequencer.sv
// Frame scheduler: walks source tiles row-major, per tile DMA read -> core pass -> DMA write to rotated slot.
// First read request 1 cycle after START; requests hold until ACK, waits stall indefinitely on DMA/core.
module rotate_tile_sequencer #(
  parameter int P_TILE_DIM = 8,
  parameter int P_BPP      = 3,
  parameter int P_ADDR_W   = 32
) (
  input  logic I_TS_HCLK,
  input  logic I_TS_HRESET_N,
  rotate_tile_sequencer_if.master ts
);
  localparam int                 LG        = $clog2(P_TILE_DIM);
  localparam int                 CW        = 16 - LG;
  localparam logic [15:0]        DIM_MASK  = 16'(P_TILE_DIM - 1);
  localparam logic [CW-1:0]      ONE       = CW'(1);
  localparam logic [P_ADDR_W-1:0] TILE_ROW = P_ADDR_W'(P_TILE_DIM * P_BPP);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_CORE_GO, S_CORE_WAIT,
    S_WR_REQ, S_WR_WAIT, S_NEXT, S_FIN
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_tx, r_ty, r_tx_n, r_ty_n;
  logic [1:0]          r_q;
  logic [P_ADDR_W-1:0] r_ss;
  logic [15:0]         r_sd;
  logic [P_ADDR_W-1:0] r_src_base, r_dst_base;
  logic                r_rd_req, r_wr_req, r_core_go, r_busy, r_done, r_err;
  logic [P_ADDR_W-1:0] r_addr;
  logic [15:0]         r_stride;

  logic                w_cfg_ok;
  logic [1:0]          w_q_in;
  logic [15:0]         w_sd_dim, w_sd_in;
  logic [P_ADDR_W-1:0] w_ss_in;
  logic [CW-1:0]       w_tx_n_in, w_ty_n_in;
  logic                w_row_end, w_last;
  logic [CW-1:0]       w_nx_tx, w_nx_ty, w_dx, w_dy;
  logic [P_ADDR_W-1:0] w_nx_src, w_dst_addr;

  // Config decode straight from the inputs, consumed only in the START cycle.
  assign w_cfg_ok  = (ts.I_TS_WIDTH != 16'd0) && ((ts.I_TS_WIDTH & DIM_MASK) == 16'd0) &&
                     (ts.I_TS_HEIGHT != 16'd0) && ((ts.I_TS_HEIGHT & DIM_MASK) == 16'd0);
  assign w_q_in    = ts.I_TS_DIRECTION ? 2'(2'd0 - ts.I_TS_DEGREES) : ts.I_TS_DEGREES;
  assign w_sd_dim  = w_q_in[0] ? ts.I_TS_HEIGHT : ts.I_TS_WIDTH;
  assign w_sd_in   = w_sd_dim * 16'(P_BPP);
  assign w_ss_in   = P_ADDR_W'(ts.I_TS_WIDTH) * P_ADDR_W'(P_BPP);
  assign w_tx_n_in = ts.I_TS_WIDTH[15:LG];
  assign w_ty_n_in = ts.I_TS_HEIGHT[15:LG];

  assign w_row_end = (r_tx == r_tx_n - ONE);
  assign w_last    = w_row_end && (r_ty == r_ty_n - ONE);
  assign w_nx_tx   = w_row_end ? '0 : r_tx + ONE;
  assign w_nx_ty   = w_row_end ? r_ty + ONE : r_ty;
  assign w_nx_src  = r_src_base + ((P_ADDR_W'(w_nx_ty) * r_ss) << LG) + P_ADDR_W'(w_nx_tx) * TILE_ROW;

  // Destination tile for q clockwise quarter-turns of the current source tile.
  always_comb begin
    w_dx = r_tx;
    w_dy = r_ty;
    case (r_q)
      2'd1: begin
        w_dx = r_ty_n - ONE - r_ty;
        w_dy = r_tx;
      end
      2'd2: begin
        w_dx = r_tx_n - ONE - r_tx;
        w_dy = r_ty_n - ONE - r_ty;
      end
      2'd3: begin
        w_dx = r_ty;
        w_dy = r_tx_n - ONE - r_tx;
      end
      default: ;
    endcase
  end

  assign w_dst_addr = r_dst_base + ((P_ADDR_W'(w_dy) * P_ADDR_W'(r_sd)) << LG) + P_ADDR_W'(w_dx) * TILE_ROW;

  always_ff @(posedge I_TS_HCLK or negedge I_TS_HRESET_N) begin
    if (!I_TS_HRESET_N) begin
      r_state    <= S_IDLE;
      r_tx       <= '0;
      r_ty       <= '0;
      r_tx_n     <= '0;
      r_ty_n     <= '0;
      r_q        <= '0;
      r_ss       <= '0;
      r_sd       <= '0;
      r_src_base <= '0;
      r_dst_base <= '0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_addr     <= '0;
      r_stride   <= '0;
      r_core_go  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (ts.I_TS_RESET) begin
      r_state    <= S_IDLE;
      r_tx       <= '0;
      r_ty       <= '0;
      r_tx_n     <= '0;
      r_ty_n     <= '0;
      r_q        <= '0;
      r_ss       <= '0;
      r_sd       <= '0;
      r_src_base <= '0;
      r_dst_base <= '0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_addr     <= '0;
      r_stride   <= '0;
      r_core_go  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_core_go <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ts.I_TS_START) begin
            r_src_base <= ts.I_TS_SRC_BASE;
            r_dst_base <= ts.I_TS_DST_BASE;
            r_tx_n     <= w_tx_n_in;
            r_ty_n     <= w_ty_n_in;
            r_q        <= w_q_in;
            r_ss       <= w_ss_in;
            r_sd       <= w_sd_in;
            r_tx       <= '0;
            r_ty       <= '0;
            if (w_cfg_ok) begin
              // Tile (0,0) sits at the source base, so the first request needs no address math.
              r_busy   <= 1'b1;
              r_rd_req <= 1'b1;
              r_addr   <= ts.I_TS_SRC_BASE;
              r_stride <= w_ss_in[15:0];
              r_state  <= S_RD_REQ;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RD_REQ: begin
          if (ts.I_TS_ACK) begin
            r_rd_req <= 1'b0;
            r_addr   <= '0;
            r_stride <= '0;
            if (ts.I_TS_XFER_DONE) begin
              r_core_go <= 1'b1;
              r_state   <= S_CORE_GO;
            end else begin
              r_state <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (ts.I_TS_XFER_DONE) begin
            r_core_go <= 1'b1;
            r_state   <= S_CORE_GO;
          end
        end
        S_CORE_GO: r_state <= S_CORE_WAIT;
        S_CORE_WAIT: begin
          if (ts.I_TS_CORE_DONE) begin
            r_wr_req <= 1'b1;
            r_addr   <= w_dst_addr;
            r_stride <= r_sd;
            r_state  <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (ts.I_TS_ACK) begin
            r_wr_req <= 1'b0;
            r_addr   <= '0;
            r_stride <= '0;
            r_state  <= ts.I_TS_XFER_DONE ? S_NEXT : S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (ts.I_TS_XFER_DONE) r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (w_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FIN;
          end else begin
            r_tx     <= w_nx_tx;
            r_ty     <= w_nx_ty;
            r_rd_req <= 1'b1;
            r_addr   <= w_nx_src;
            r_stride <= r_ss[15:0];
            r_state  <= S_RD_REQ;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ts.O_TS_RD_REQ  = r_rd_req;
  assign ts.O_TS_WR_REQ  = r_wr_req;
  assign ts.O_TS_ADDR    = r_addr;
  assign ts.O_TS_STRIDE  = r_stride;
  assign ts.O_TS_CORE_GO = r_core_go;
  assign ts.O_TS_BUSY    = r_busy;
  assign ts.O_TS_DONE    = r_done;
  assign ts.O_TS_ERR     = r_err;
endmodule

// File: tb/tb_rotate_tile_sequencer.sv
// Scoreboard bench: directed frames push expected DMA/core/done events; a negedge monitor pops and compares.
module tb_rotate_tile_sequencer;
  localparam int EV_RD = 0, EV_WR = 1, EV_GO = 2, EV_DONE = 3, EV_ERR = 4;

  typedef struct packed {
    logic [7:0]  kind;
    logic [31:0] addr;
    logic [15:0] stride;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rotate_tile_sequencer_if #(.P_ADDR_W(32)) ts_if ();

  rotate_tile_sequencer #(.P_TILE_DIM(8), .P_BPP(3), .P_ADDR_W(32)) dut (
    .I_TS_HCLK    (clk),
    .I_TS_HRESET_N(rst_n),
    .ts           (ts_if)
  );

  wire        rd_req  = ts_if.O_TS_RD_REQ;
  wire        wr_req  = ts_if.O_TS_WR_REQ;
  wire [31:0] addr    = ts_if.O_TS_ADDR;
  wire [15:0] stride  = ts_if.O_TS_STRIDE;
  wire        core_go = ts_if.O_TS_CORE_GO;
  wire        busy    = ts_if.O_TS_BUSY;
  wire        done    = ts_if.O_TS_DONE;
  wire        err     = ts_if.O_TS_ERR;
  wire [63:0] outs    = {10'd0, rd_req, wr_req, addr, stride, core_go, busy, done, err};

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  int   ev_idx = 0;

  int   ack_dly = 0;
  int   xfer_gap = 0;
  bit   xfer_same = 1'b1;
  bit   hold_core = 1'b0;
  bit   hold_wr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] a, input logic [15:0] s);
    ev_t e;
    e.kind = 8'(kind);
    e.addr = a;
    e.stride = s;
    exp_q.push_back(e);
  endtask

  task automatic push_tile(input logic [31:0] ra, input logic [15:0] rs,
                           input logic [31:0] wa, input logic [15:0] ws);
    push_ev(EV_RD, ra, rs);
    push_ev(EV_GO, 32'd0, 16'd0);
    push_ev(EV_WR, wa, ws);
  endtask

  task automatic observe(input int kind, input logic [31:0] a, input logic [15:0] s);
    ev_t act;
    ev_t e;
    act.kind = 8'(kind);
    act.addr = a;
    act.stride = s;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=0x%0h stride=%0d expected none", kind, a, s);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("event%0d", ev_idx), 64'(act), 64'(e));
    end
    ev_idx++;
  endtask

  // DMA and core responder.
  initial begin : responder
    int phase;
    int cnt;
    bit wr_acc;
    phase = 0;
    cnt = 0;
    wr_acc = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ts_if.I_TS_ACK = 1'b0;
      ts_if.I_TS_XFER_DONE = 1'b0;
      ts_if.I_TS_CORE_DONE = 1'b0;
      if (!rst_n || ts_if.I_TS_RESET) begin
        phase = 0;
        cnt = 0;
      end else begin
        case (phase)
          0: begin
            if (core_go) begin
              phase = 3;
            end else if (rd_req || wr_req) begin
              if (cnt >= ack_dly) begin
                ts_if.I_TS_ACK = 1'b1;
                wr_acc = wr_req;
                cnt = 0;
                if (xfer_same) ts_if.I_TS_XFER_DONE = 1'b1;
                else phase = 2;
              end else begin
                cnt++;
              end
            end
          end
          2: begin
            if (cnt >= xfer_gap && !(wr_acc && hold_wr)) begin
              ts_if.I_TS_XFER_DONE = 1'b1;
              phase = 0;
              cnt = 0;
            end else begin
              cnt++;
            end
          end
          3: begin
            if (!hold_core) begin
              ts_if.I_TS_CORE_DONE = 1'b1;
              phase = 0;
            end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  logic        prev_rd = 1'b0, prev_wr = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_stride = '0;

  always @(negedge clk) begin
    chk("rd_wr_exclusive", 64'(rd_req & wr_req), 64'd0);
    if (!rd_req && !wr_req) chk("bus_zero_no_req", {16'd0, addr, stride}, 64'd0);
    if (rd_req && prev_rd && !prev_ack) chk("rd_hold", {addr, stride}, {prev_addr, prev_stride});
    if (wr_req && prev_wr && !prev_ack) chk("wr_hold", {addr, stride}, {prev_addr, prev_stride});
    if (prev_ack && prev_rd) chk("rd_drop_after_ack", 64'(rd_req), 64'd0);
    if (prev_ack && prev_wr) chk("wr_drop_after_ack", 64'(wr_req), 64'd0);
    if (rst_n) begin
      if (ts_if.I_TS_ACK && rd_req) observe(EV_RD, addr, stride);
      if (ts_if.I_TS_ACK && wr_req) observe(EV_WR, addr, stride);
      if (core_go) observe(EV_GO, 32'd0, 16'd0);
      if (done) begin
        observe(EV_DONE, 32'd0, 16'd0);
        chk("busy_low_at_done", 64'(busy), 64'd0);
      end
      if (err) observe(EV_ERR, 32'd0, 16'd0);
    end
    prev_rd     <= rd_req;
    prev_wr     <= wr_req;
    prev_ack    <= ts_if.I_TS_ACK;
    prev_addr   <= addr;
    prev_stride <= stride;
  end

  task automatic start_frame(input logic [15:0] w, input logic [15:0] h, input logic [1:0] deg,
                             input logic dir, input logic [31:0] src, input logic [31:0] dst,
                             input bit ok);
    @(posedge clk);
    #1;
    ts_if.I_TS_WIDTH = w;
    ts_if.I_TS_HEIGHT = h;
    ts_if.I_TS_DEGREES = deg;
    ts_if.I_TS_DIRECTION = dir;
    ts_if.I_TS_SRC_BASE = src;
    ts_if.I_TS_DST_BASE = dst;
    ts_if.I_TS_START = 1'b1;
    @(posedge clk);
    #1;
    ts_if.I_TS_START = 1'b0;
    @(negedge clk);
    if (ok) chk("start_to_rdreq", {62'd0, busy, rd_req}, 64'b11);
    else    chk("start_rejected", {61'd0, busy, rd_req, err}, 64'b001);
  endtask

  task automatic wait_drain(input string name, input int budget, input bit need_idle);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || (need_idle && busy)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got %0d events pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic set_rsp(input int ad, input bit same, input int gap);
    ack_dly = ad;
    xfer_same = same;
    xfer_gap = gap;
  endtask

  task automatic push_16x16_q0();
    push_tile(32'h1000, 16'd48, 32'h8000, 16'd48);
    push_tile(32'h1018, 16'd48, 32'h8018, 16'd48);
    push_tile(32'h1180, 16'd48, 32'h8180, 16'd48);
    push_tile(32'h1198, 16'd48, 32'h8198, 16'd48);
    push_ev(EV_DONE, 32'd0, 16'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ts_if.I_TS_RESET = 1'b0;
    ts_if.I_TS_START = 1'b0;
    ts_if.I_TS_WIDTH = 16'd0;
    ts_if.I_TS_HEIGHT = 16'd0;
    ts_if.I_TS_DEGREES = 2'd0;
    ts_if.I_TS_DIRECTION = 1'b0;
    ts_if.I_TS_SRC_BASE = 32'd0;
    ts_if.I_TS_DST_BASE = 32'd0;
    ts_if.I_TS_ACK = 1'b0;
    ts_if.I_TS_XFER_DONE = 1'b0;
    ts_if.I_TS_CORE_DONE = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs", outs, 64'd0);

    // 16x16 no rotation, immediate ack with same-cycle completion; a bad START mid-frame is ignored.
    set_rsp(0, 1'b1, 0);
    push_16x16_q0();
    start_frame(16'd16, 16'd16, 2'd0, 1'b0, 32'h1000, 32'h8000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    ts_if.I_TS_WIDTH = 16'd12;
    ts_if.I_TS_START = 1'b1;
    @(posedge clk);
    #1;
    ts_if.I_TS_START = 1'b0;
    wait_drain("q0_16x16", 500, 1'b1);

    // 16x8 CW90, ack held off five cycles.
    set_rsp(5, 1'b0, 2);
    push_tile(32'h1000, 16'd48, 32'h8000, 16'd24);
    push_tile(32'h1018, 16'd48, 32'h80C0, 16'd24);
    push_ev(EV_DONE, 32'd0, 16'd0);
    start_frame(16'd16, 16'd8, 2'd1, 1'b0, 32'h1000, 32'h8000, 1'b1);
    wait_drain("cw90_16x8", 500, 1'b1);

    // 16x8 CCW90 (three clockwise quarter-turns).
    set_rsp(1, 1'b0, 0);
    push_tile(32'h1000, 16'd48, 32'h80C0, 16'd24);
    push_tile(32'h1018, 16'd48, 32'h8000, 16'd24);
    push_ev(EV_DONE, 32'd0, 16'd0);
    start_frame(16'd16, 16'd8, 2'd1, 1'b1, 32'h1000, 32'h8000, 1'b1);
    wait_drain("ccw90_16x8", 500, 1'b1);

    // 16x16 180 degrees with other bases.
    set_rsp(0, 1'b1, 0);
    push_tile(32'h2000, 16'd48, 32'h9198, 16'd48);
    push_tile(32'h2018, 16'd48, 32'h9180, 16'd48);
    push_tile(32'h2180, 16'd48, 32'h9018, 16'd48);
    push_tile(32'h2198, 16'd48, 32'h9000, 16'd48);
    push_ev(EV_DONE, 32'd0, 16'd0);
    start_frame(16'd16, 16'd16, 2'd2, 1'b0, 32'h2000, 32'h9000, 1'b1);
    wait_drain("r180_16x16", 500, 1'b1);

    // 8x16 at DEG=3 clockwise, then DEG=3 counter-clockwise.
    set_rsp(0, 1'b0, 1);
    push_tile(32'h1000, 16'd24, 32'h8000, 16'd48);
    push_tile(32'h10C0, 16'd24, 32'h8018, 16'd48);
    push_ev(EV_DONE, 32'd0, 16'd0);
    start_frame(16'd8, 16'd16, 2'd3, 1'b0, 32'h1000, 32'h8000, 1'b1);
    wait_drain("cw270_8x16", 500, 1'b1);
    push_tile(32'h1000, 16'd24, 32'h8018, 16'd48);
    push_tile(32'h10C0, 16'd24, 32'h8000, 16'd48);
    push_ev(EV_DONE, 32'd0, 16'd0);
    start_frame(16'd8, 16'd16, 2'd3, 1'b1, 32'h1000, 32'h8000, 1'b1);
    wait_drain("ccw270_8x16", 500, 1'b1);

    // Rejected configurations.
    push_ev(EV_ERR, 32'd0, 16'd0);
    start_frame(16'd12, 16'd8, 2'd0, 1'b0, 32'h1000, 32'h8000, 1'b0);
    wait_drain("err_w12", 50, 1'b1);
    push_ev(EV_ERR, 32'd0, 16'd0);
    start_frame(16'd16, 16'd0, 2'd0, 1'b0, 32'h1000, 32'h8000, 1'b0);
    wait_drain("err_h0", 50, 1'b1);
    chk("idle_after_err", outs, 64'd0);

    // Async reset while the core is working on tile 0, then a clean rerun.
    set_rsp(0, 1'b1, 0);
    hold_core = 1'b1;
    push_ev(EV_RD, 32'h1000, 16'd48);
    push_ev(EV_GO, 32'd0, 16'd0);
    start_frame(16'd16, 16'd16, 2'd0, 1'b0, 32'h1000, 32'h8000, 1'b1);
    wait_drain("abort_core_wait", 200, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_abort_outputs", outs, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("async_abort_held", outs, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold_core = 1'b0;
    repeat (6) @(negedge clk);
    chk("async_abort_idle", outs, 64'd0);
    push_16x16_q0();
    start_frame(16'd16, 16'd16, 2'd0, 1'b0, 32'h1000, 32'h8000, 1'b1);
    wait_drain("rerun_after_async", 500, 1'b1);

    // Soft reset while waiting on the tile 0 write, then a clean rerun.
    set_rsp(0, 1'b0, 0);
    hold_wr = 1'b1;
    push_tile(32'h1000, 16'd48, 32'h8000, 16'd48);
    start_frame(16'd16, 16'd8, 2'd0, 1'b0, 32'h1000, 32'h8000, 1'b1);
    wait_drain("abort_wr_wait", 200, 1'b0);
    @(posedge clk);
    #1 ts_if.I_TS_RESET = 1'b1;
    repeat (2) @(posedge clk);
    #1 ts_if.I_TS_RESET = 1'b0;
    @(negedge clk);
    chk("soft_abort_outputs", outs, 64'd0);
    hold_wr = 1'b0;
    repeat (6) @(negedge clk);
    chk("soft_abort_idle", outs, 64'd0);
    push_tile(32'h1000, 16'd48, 32'h8000, 16'd48);
    push_tile(32'h1018, 16'd48, 32'h8018, 16'd48);
    push_ev(EV_DONE, 32'd0, 16'd0);
    start_frame(16'd16, 16'd8, 2'd0, 1'b0, 32'h1000, 32'h8000, 1'b1);
    wait_drain("rerun_after_soft", 500, 1'b1);

    chk("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
